// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: byte-command master for the system register file.
//   AA <addr> <data> : one-cycle write strobe
//   BB <addr>        : one-cycle read strobe, the read data goes back to the UART TX
// All outputs are registered. The CLK/RST/RX_*/TX_* names follow the surrounding
// UART and register-file blocks.
// Build option: define RD_TIMEOUT_EN to bound RD_WAIT. On timeout, ERR_BYTE is
// returned after TIMEOUT_CYCLES cycles. Without the macro, RD_WAIT waits forever.
module reg_access_ctrl #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD         = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD         = 8'hBB,
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE       = 8'hEE,
    parameter int                    TIMEOUT_CYCLES = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  TX_Busy,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        RESP    = 3'd5,
        PULSE   = 3'd6
    } state_t;

    state_t state, next_state;

    logic                  rd_to;   // RD_WAIT has expired this cycle
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wr_data_nxt;
    logic [DATA_WIDTH-1:0] tx_data_nxt;
    logic                  wr_en_nxt;
    logic                  rd_en_nxt;
    logic                  tx_vld_nxt;

`ifdef RD_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;

    // Wait counter: 0 in the first RD_WAIT cycle, so it expires in the TIMEOUT_CYCLES-th cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                  to_cnt <= '0;
        else if (state == RD_WAIT) to_cnt <= to_cnt + 1'b1;
        else                       to_cnt <= '0;
    end

    assign rd_to = (state == RD_WAIT) && (to_cnt == TO_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
    assign rd_to      = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decode. Once read data is ready, the FSM goes straight to PULSE
    // if TX was free in that same cycle. This keeps the n+3 read-to-TX latency
    // with registered outputs. RESP is only a holding state while TX is busy.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == WR_CMD)      next_state = WR_ADDR;
                else if (RX_P_DATA == RD_CMD) next_state = RD_ADDR;
            end
            WR_ADDR: if (RX_D_VLD) next_state = WR_DATA;
            WR_DATA: if (RX_D_VLD) next_state = IDLE;
            RD_ADDR: if (RX_D_VLD) next_state = RD_WAIT;
            RD_WAIT: if (RdData_Valid || rd_to) next_state = TX_Busy ? RESP : PULSE;
            RESP:    if (!TX_Busy) next_state = PULSE;
            PULSE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next output values. Address and WrData hold between commands.
    // Read data takes priority over a timeout that expires in the same cycle.
    always_comb begin
        addr_nxt    = Address;
        wr_data_nxt = WrData;
        tx_data_nxt = TX_P_DATA;
        wr_en_nxt   = (state == WR_DATA) && RX_D_VLD;
        rd_en_nxt   = (state == RD_ADDR) && RX_D_VLD;
        tx_vld_nxt  = (next_state == PULSE);
        if (((state == WR_ADDR) || (state == RD_ADDR)) && RX_D_VLD)
            addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
        if ((state == WR_DATA) && RX_D_VLD)
            wr_data_nxt = RX_P_DATA;
        if (state == RD_WAIT) begin
            if (RdData_Valid) tx_data_nxt = RdData;
            else if (rd_to)   tx_data_nxt = ERR_BYTE;
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Address   <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
        end else begin
            Address   <= addr_nxt;
            WrEn      <= wr_en_nxt;
            RdEn      <= rd_en_nxt;
            WrData    <= wr_data_nxt;
            TX_P_DATA <= tx_data_nxt;
            TX_D_VLD  <= tx_vld_nxt;
        end
    end

endmodule
